sipo_rx: RTL and testbench

SIPO_RX -- requirements
Module: sipo_rx

---
 rtl/sipo_rx_pkg.sv | 16 +
 rtl/sipo_rx_outbuf.sv | 78 +++++++
 rtl/sipo_rx.sv | 137 +++++++++++++
 tb/tb_sipo_rx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_rx_pkg.sv
// Shared types and sizing helpers for the serial-in/parallel-out receiver.
// Optional parity support is selected by the SIPO_RX_PARITY_EN macro.
package sipo_rx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        PAR  = 2'd2
    } rx_state_e;

    // Bit counter must represent 0..width inclusive.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_rx_outbuf.sv
// Output word buffer for sipo_rx: holds the completed word and runs the valid/ready handshake.
// With SIPO_RX_PARITY_EN defined a parity error flag travels alongside the word.
module sipo_rx_outbuf
    import sipo_rx_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             complete,
    input  logic [WIDTH-1:0] word,
`ifdef SIPO_RX_PARITY_EN
    input  logic             perr,
    output logic             parity_err,
`endif
    input  logic             data_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
`ifdef SIPO_RX_PARITY_EN
    logic             perr_q, perr_d;
`endif

    // A new word is taken when the buffer is empty or being drained at the same edge.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
`ifdef SIPO_RX_PARITY_EN
        perr_d  = perr_q;
`endif
        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end
        if (complete) begin
            if (!valid_q || data_ready) begin
                data_d  = word;
                valid_d = 1'b1;
`ifdef SIPO_RX_PARITY_EN
                perr_d  = perr;
`endif
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
`ifdef SIPO_RX_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign overrun    = ovr_q;
`ifdef SIPO_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: shift register and receive FSM, feeding sipo_rx_outbuf.
// Define SIPO_RX_PARITY_EN to append one even-parity bit to each frame.
module sipo_rx
    import sipo_rx_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             serial_in,
    input  logic             data_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             busy,
`ifdef SIPO_RX_PARITY_EN
    output logic             parity_err,
`endif
    output logic             overrun
);

    localparam int unsigned CW = cnt_width(WIDTH);

    rx_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] shift_c;
    logic [WIDTH-1:0] word_c;
    logic             complete_c;
`ifdef SIPO_RX_PARITY_EN
    logic             perr_c;
`endif

    // Shift direction decides which end the first received bit ends up at.
    always_comb begin
        if (MSB_FIRST != 0) begin
            shift_c = {sr_q[WIDTH-2:0], serial_in};
        end else begin
            shift_c = {serial_in, sr_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        word_c     = sr_q;
        complete_c = 1'b0;
`ifdef SIPO_RX_PARITY_EN
        perr_c     = 1'b0;
`endif
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            sr_d    = '0;
        end else if (shift_en) begin
            unique case (state_q)
                IDLE: begin
                    state_d = RECV;
                    cnt_d   = CW'(1);
                    sr_d    = shift_c;
                end
                RECV: begin
                    if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SIPO_RX_PARITY_EN
                        state_d = PAR;
                        cnt_d   = CW'(WIDTH);
                        sr_d    = shift_c;
`else
                        state_d    = IDLE;
                        cnt_d      = '0;
                        sr_d       = '0;
                        word_c     = shift_c;
                        complete_c = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        sr_d  = shift_c;
                    end
                end
`ifdef SIPO_RX_PARITY_EN
                PAR: begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    sr_d       = '0;
                    word_c     = sr_q;
                    complete_c = 1'b1;
                    perr_c     = ^{sr_q, serial_in};
                end
`endif
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    sr_d    = '0;
                end
            endcase
        end
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;

    sipo_rx_outbuf #(
        .WIDTH(WIDTH)
    ) u_outbuf (
        .clk       (clk),
        .reset     (reset),
        .complete  (complete_c),
        .word      (word_c),
`ifdef SIPO_RX_PARITY_EN
        .perr      (perr_c),
        .parity_err(parity_err),
`endif
        .data_ready(data_ready),
        .data_out  (data_out),
        .data_valid(data_valid),
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx: MSB-first and LSB-first instances share one stimulus stream.
// Frames carry a trailing even-parity bit when SIPO_RX_PARITY_EN is defined.
module tb_sipo_rx;

    logic       clk = 1'b0;
    logic       reset, clear, shift_en, serial_in, data_ready;
    logic [3:0] data_out, data_out_l;
    logic       data_valid, busy, overrun;
    logic       data_valid_l, busy_l, overrun_l;
`ifdef SIPO_RX_PARITY_EN
    logic       parity_err, parity_err_l;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sipo_rx #(.WIDTH(4), .MSB_FIRST(1)) dut (
        .clk(clk), .reset(reset), .clear(clear), .shift_en(shift_en),
        .serial_in(serial_in), .data_ready(data_ready), .data_out(data_out),
        .data_valid(data_valid), .busy(busy),
`ifdef SIPO_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .overrun(overrun)
    );

    sipo_rx #(.WIDTH(4), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .reset(reset), .clear(clear), .shift_en(shift_en),
        .serial_in(serial_in), .data_ready(data_ready), .data_out(data_out_l),
        .data_valid(data_valid_l), .busy(busy_l),
`ifdef SIPO_RX_PARITY_EN
        .parity_err(parity_err_l),
`endif
        .overrun(overrun_l)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        shift_en  = 1'b1;
        serial_in = b;
        tick();
        shift_en  = 1'b0;
        serial_in = 1'b0;
    endtask

    // seq[3] goes first; rdy_last raises data_ready for the final frame bit.
    task automatic send_word(input logic [3:0] seq, input logic rdy_last);
        for (int i = 3; i >= 0; i--) begin
`ifndef SIPO_RX_PARITY_EN
            if (i == 0 && rdy_last) data_ready = 1'b1;
`endif
            send_bit(seq[i]);
        end
`ifdef SIPO_RX_PARITY_EN
        if (rdy_last) data_ready = 1'b1;
        send_bit(^seq);
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; shift_en = 1'b0; serial_in = 1'b0; data_ready = 1'b0;
        #1;
        checks++; if (data_out !== 4'b0000) begin errors++; $display("FAIL rst_data: got %b expected 0000", data_out); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", data_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b expected 0", overrun); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_msb_first();
        data_ready = 1'b1;
        send_bit(1'b1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL msb_busy_first: got %b expected 1", busy); end
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
`ifdef SIPO_RX_PARITY_EN
        send_bit(1'b1);
`endif
        checks++; if (data_out !== 4'b1101) begin errors++; $display("FAIL msb_data: got %b expected 1101", data_out); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL msb_valid: got %b expected 1", data_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL msb_busy_done: got %b expected 0", busy); end
        checks++; if (data_out_l !== 4'b1011) begin errors++; $display("FAIL msb_lsb_twin: got %b expected 1011", data_out_l); end
        tick();
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL msb_valid_drop: got %b expected 0", data_valid); end
    endtask

    task automatic test_lsb_gap();
        data_ready = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        repeat (3) tick();
        checks++; if (busy_l !== 1'b1) begin errors++; $display("FAIL gap_busy: got %b expected 1", busy_l); end
        checks++; if (data_valid_l !== 1'b0) begin errors++; $display("FAIL gap_valid: got %b expected 0", data_valid_l); end
        send_bit(1'b0);
        send_bit(1'b1);
`ifdef SIPO_RX_PARITY_EN
        send_bit(1'b1);
`endif
        checks++; if (data_out_l !== 4'b1011) begin errors++; $display("FAIL lsb_data: got %b expected 1011", data_out_l); end
        checks++; if (data_valid_l !== 1'b1) begin errors++; $display("FAIL lsb_valid: got %b expected 1", data_valid_l); end
        tick();
    endtask

    task automatic test_overrun();
        data_ready = 1'b0;
        send_word(4'b1010, 1'b0);
        checks++; if (data_out !== 4'b1010) begin errors++; $display("FAIL ovr_first: got %b expected 1010", data_out); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early: got %b expected 0", overrun); end
        send_word(4'b0110, 1'b0);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_pulse: got %b expected 1", overrun); end
        checks++; if (data_out !== 4'b1010) begin errors++; $display("FAIL ovr_hold: got %b expected 1010", data_out); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b expected 1", data_valid); end
        tick();
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_one_cycle: got %b expected 0", overrun); end
        checks++; if (data_out !== 4'b1010) begin errors++; $display("FAIL ovr_stable: got %b expected 1010", data_out); end
        data_ready = 1'b1;
        tick();
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain: got %b expected 0", data_valid); end
    endtask

    task automatic test_clear();
        data_ready = 1'b1;
        send_bit(1'b1);
        send_bit(1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy_before: got %b expected 1", busy); end
        clear = 1'b1; shift_en = 1'b1; serial_in = 1'b1;
        tick();
        clear = 1'b0; shift_en = 1'b0; serial_in = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy_after: got %b expected 0", busy); end
        send_word(4'b0011, 1'b0);
        checks++; if (data_out !== 4'b0011) begin errors++; $display("FAIL clr_data: got %b expected 0011", data_out); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL clr_valid: got %b expected 1", data_valid); end
        tick();
        data_ready = 1'b0;
        send_word(4'b0101, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL clr_pending_valid: got %b expected 1", data_valid); end
        checks++; if (data_out !== 4'b0101) begin errors++; $display("FAIL clr_pending_data: got %b expected 0101", data_out); end
        data_ready = 1'b1;
        tick();
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL clr_drain: got %b expected 0", data_valid); end
    endtask

    task automatic test_reset_mid();
        data_ready = 1'b0;
        send_word(4'b1110, 1'b0);
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL rmid_pending: got %b expected 1", data_valid); end
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        #2 reset = 1'b1;
        #1;
        checks++; if (data_out !== 4'b0000) begin errors++; $display("FAIL rmid_data: got %b expected 0000", data_out); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", data_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rmid_overrun: got %b expected 0", overrun); end
        @(negedge clk);
        reset = 1'b0;
        tick();
        data_ready = 1'b1;
        send_bit(1'b1);
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_word: got %b expected 0", data_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_restart_busy: got %b expected 1", busy); end
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
`ifdef SIPO_RX_PARITY_EN
        send_bit(1'b0);
`endif
        checks++; if (data_out !== 4'b1001) begin errors++; $display("FAIL rmid_new_word: got %b expected 1001", data_out); end
        tick();
    endtask

    task automatic test_back_to_back();
        data_ready = 1'b1;
        send_word(4'b1100, 1'b0);
        checks++; if (data_out !== 4'b1100) begin errors++; $display("FAIL b2b_first: got %b expected 1100", data_out); end
        send_word(4'b0111, 1'b0);
        checks++; if (data_out !== 4'b0111) begin errors++; $display("FAIL b2b_second: got %b expected 0111", data_out); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", data_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
        data_ready = 1'b0;
        send_word(4'b1011, 1'b1);
        checks++; if (data_out !== 4'b1011) begin errors++; $display("FAIL same_edge_data: got %b expected 1011", data_out); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL same_edge_valid: got %b expected 1", data_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL same_edge_overrun: got %b expected 0", overrun); end
        tick();
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", data_valid); end
    endtask

`ifdef SIPO_RX_PARITY_EN
    task automatic test_parity();
        data_ready = 1'b1;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL par_good: got %b expected 0", parity_err); end
        checks++; if (data_out !== 4'b1101) begin errors++; $display("FAIL par_good_data: got %b expected 1101", data_out); end
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL par_bad: got %b expected 1", parity_err); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL par_bad_valid: got %b expected 1", data_valid); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_gap();
        test_overrun();
        test_clear();
        test_reset_mid();
        test_back_to_back();
`ifdef SIPO_RX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
